sprite_port_bank: RTL

Parametrised, frame-coherent register bank between the NIOS PIO export ports and `frame_displayer`. Software writes the sprite descriptors into `port_in`, then raises a request on `to_hw_sig`. The bank captures all channels into shadow registers at once and transfers them to `port_out` only on the next vertical-sync falling edge, so the displayer never shows a half-updated sprite set. It replaces direct wiring of the PIO exports and reports handshake status back on `to_sw_sig`, along with frame and stale-frame counters.

---
 rtl/veggie_pkg.sv | 46 ++++
 rtl/edge_detect_fall.sv | 32 +++
 rtl/sprite_port_bank.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/veggie_pkg.sv
// veggie_pkg
// Shared types and default sizing for the sprite descriptor path between
// the NIOS PIO exports and frame_displayer.
//   hw_cmd_t     : software command encoding on to_hw_sig
//   sw_stat_t    : status encoding reported on to_sw_sig
//   bank_state_t : sprite_port_bank handshake FSM states
package veggie_pkg;

    localparam int DEF_NUM_CH = 16;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;

    // 2'b10 is reserved and is treated as CMD_IDLE by the bank.
    typedef enum logic [1:0] {
        CMD_IDLE   = 2'b00,
        CMD_REQ    = 2'b01,
        CMD_CANCEL = 2'b11
    } hw_cmd_t;

    typedef enum logic [1:0] {
        STAT_READY     = 2'b00,
        STAT_CAPTURED  = 2'b01,
        STAT_COMMITTED = 2'b10,
        STAT_CANCELLED = 2'b11
    } sw_stat_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ARMED     = 2'b01,
        ST_DONE      = 2'b10,
        ST_CANCELLED = 2'b11
    } bank_state_t;

    // Status reported to software for a given bank state.
    function automatic sw_stat_t state_to_stat(input bank_state_t st);
        sw_stat_t stat;
        case (st)
            ST_IDLE:      stat = STAT_READY;
            ST_ARMED:     stat = STAT_CAPTURED;
            ST_DONE:      stat = STAT_COMMITTED;
            default:      stat = STAT_CANCELLED;
        endcase
        return stat;
    endfunction

endpackage

// File: rtl/edge_detect_fall.sv
// edge_detect_fall
// Falling-edge detector for a signal already in the clk domain (no
// synchroniser). Also used for the GPIO button edges.
//   clk     : clock
//   reset_n : synchronous active-low reset
//   sig     : monitored signal
//   fall    : high for the cycle in which sig is low and was high last cycle
module edge_detect_fall #(
    // Reset value of the delayed copy. Use the idle level of the signal so
    // that a signal sitting at its idle level after reset does not produce
    // a spurious edge.
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic fall
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sig_q <= RESET_LEVEL;
        end else begin
            sig_q <= sig;
        end
    end

    assign fall = sig_q & ~sig;

endmodule

// File: rtl/sprite_port_bank.sv
// sprite_port_bank
// Frame-coherent register bank between the PIO exports and frame_displayer.
// Software stages descriptors on port_in and raises REQ; all channels are
// captured into a shadow bank at once and copied to port_out only on the
// next vsync falling edge, so a frame never shows a half-updated sprite set.
//
// Handshake (to_hw_sig / to_sw_sig): software issues REQ (01) from READY;
// the bank answers CAPTURED (01). On the next vsync fall the bank answers
// COMMITTED (10); a CANCEL (11) while CAPTURED answers CANCELLED (11)
// instead. From COMMITTED/CANCELLED software must return to IDLE (00, or the
// reserved 10) to get READY back; a held REQ never captures twice.
//
// Ports:
//   Clk         : system clock
//   Reset_n     : synchronous active-low reset
//   port_in     : staging descriptors written by software
//   to_hw_sig   : software command
//   vsync_n     : VGA vertical sync, active low, same clock domain
//   port_out    : active descriptors
//   to_sw_sig   : registered status (mirrors the FSM state)
//   frame_tick  : one-cycle pulse after each vsync falling edge
//   frame_count : vsync falling edges seen, wrapping
//   stale_count : frames begun without a pending commit, saturating
module sprite_port_bank
    import veggie_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  port_in,
    input  logic [1:0]                     to_hw_sig,
    input  logic                           vsync_n,
    output logic [NUM_CH-1:0][DATA_W-1:0]  port_out,
    output logic [1:0]                     to_sw_sig,
    output logic                           frame_tick,
    output logic [CNT_W-1:0]               frame_count,
    output logic [CNT_W-1:0]               stale_count
);

    bank_state_t                  state;
    bank_state_t                  state_next;
    logic                         vs_fall;
    logic                         load_shadow;
    logic                         commit;
    logic [NUM_CH-1:0][DATA_W-1:0] shadow;

    logic is_req;
    logic is_cancel;
    logic is_release;

    assign is_req     = (to_hw_sig == CMD_REQ);
    assign is_cancel  = (to_hw_sig == CMD_CANCEL);
    // 00 and the reserved 10 both release the bank.
    assign is_release = (to_hw_sig[0] == 1'b0);

    edge_detect_fall #(
        .RESET_LEVEL (1'b1)
    ) u_vs_edge (
        .clk     (Clk),
        .reset_n (Reset_n),
        .sig     (vsync_n),
        .fall    (vs_fall)
    );

    // ---------------------------------------------------------------
    // FSM next-state / control
    // ---------------------------------------------------------------
    always_comb begin
        state_next  = state;
        load_shadow = 1'b0;
        commit      = 1'b0;
        case (state)
            ST_IDLE: begin
                // A REQ on the same cycle as vs_fall only captures; the
                // commit waits for the following frame edge.
                if (is_req) begin
                    load_shadow = 1'b1;
                    state_next  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // Commit has priority over a coincident CANCEL.
                if (vs_fall) begin
                    commit     = 1'b1;
                    state_next = ST_DONE;
                end else if (is_cancel) begin
                    state_next = ST_CANCELLED;
                end
            end
            ST_DONE, ST_CANCELLED: begin
                if (is_release) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            to_sw_sig <= STAT_READY;
        end else begin
            state     <= state_next;
            to_sw_sig <= state_to_stat(state_next);
        end
    end

    // ---------------------------------------------------------------
    // Shadow and active descriptor banks
    // ---------------------------------------------------------------
    // A cancelled shadow is never read again: the only way back to ARMED
    // reloads it, so no explicit clear is needed on cancel.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            shadow <= '0;
        end else if (load_shadow) begin
            shadow <= port_in;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            port_out <= '0;
        end else if (commit) begin
            port_out <= shadow;
        end
    end

    // ---------------------------------------------------------------
    // Frame counters
    // ---------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_tick  <= 1'b0;
            frame_count <= '0;
            stale_count <= '0;
        end else begin
            frame_tick <= vs_fall;
            if (vs_fall) begin
                frame_count <= frame_count + CNT_W'(1);
                // A frame is stale when nothing was waiting to be committed.
                if ((state != ST_ARMED) && (stale_count != {CNT_W{1'b1}})) begin
                    stale_count <= stale_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
